// File: rtl/seq_wide_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial wide adder.
package seq_wide_adder_pkg;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_wide_adder_adder.sv
// 4-bit ripple-carry adder slice; purely combinational.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

// File: rtl/seq_wide_adder.sv
// Wide adder that streams one nibble per cycle through a single 4-bit slice,
// carrying between nibbles in a register; start/done handshake.
module seq_wide_adder
    import seq_wide_adder_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t                       state;
    logic [NIBBLES-1:0][NIB_W-1:0] a_q, b_q, partial, partial_nxt;
    logic [IDX_W-1:0]             idx;
    logic                         carry_q;
    logic [NIB_W-1:0]             slice_sum;
    logic                         slice_cout;

    adder u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Partial sum including the nibble being produced this cycle, so the
    // final write and the output update happen on the same edge.
    always_comb begin
        partial_nxt      = partial;
        partial_nxt[idx] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            partial <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                RUN: begin
                    partial <= partial_nxt;
                    carry_q <= slice_cout;
                    if (idx == LAST) begin
                        sum   <= partial_nxt;
                        cout  <= slice_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // IDLE, DONE and the unused encoding are all "ready" states.
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed bench for seq_wide_adder (NIBBLES=4): vector table plus handshake corner cases.
module tb_seq_wide_adder;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs [6];

    seq_wide_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One start pulse, then watch busy/done until the result appears.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] es, input logic ec);
        int lat;
        int nbusy;
        lat = 0;
        nbusy = 0;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check({name, " sum held in RUN"}, 32'(sum), 32'(prev_sum));
                check({name, " cout held in RUN"}, 32'(cout), 32'(prev_cout));
            end
            if (done) break;
            if (busy) nbusy++;
        end
        check({name, " latency"}, 32'(lat), 32'd5);
        check({name, " busy cycles"}, 32'(nbusy), 32'd4);
        check({name, " busy low at done"}, 32'(busy), 32'd0);
        check({name, " sum"}, 32'(sum), 32'(es));
        check({name, " cout"}, 32'(cout), 32'(ec));
        prev_sum = es;
        prev_cout = ec;
        @(negedge clk);
        check({name, " done one-cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout);

        // start during RUN is ignored
        @(negedge clk);
        a = 16'h0005; b = 16'h0007; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("ignored start sum", 32'(sum), 32'h000C);
                check("ignored start cout", 32'(cout), 32'd0);
                check("ignored start latency", 32'(k + 3), 32'd5);
            end
        end
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start busy after", 32'(busy), 32'd0);
        check("ignored start sum hold", 32'(sum), 32'h000C);

        // back-to-back with start held
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("b2b done spacing", 32'(i % 5), 32'd0);
                check("b2b sum", 32'(sum), 32'h0100);
                check("b2b cout", 32'(cout), 32'd0);
            end
        end
        start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd3);
        @(negedge clk);
        check("b2b idle after", 32'(busy), 32'd0);
        prev_sum = 16'h0100;
        prev_cout = 1'b0;

        // reset mid-RUN
        @(negedge clk);
        a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset sum", 32'(sum), 32'd0);
        check("mid reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no activity after reset", 32'(ndone), 32'd0);
        prev_sum = '0;
        prev_cout = 1'b0;
        do_op("post reset", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
